tx_frame_ctrl: RTL and testbench

- Downstream stage of the system controller, in the UART TX clock domain.
- Drains 16-bit result words from the TX-side read port of the async FIFO (register-read data and ALU results) and hands them to the UART transmitter one byte at a time, low byte first.
- Each word is sent as 2 bytes or 1 byte (low byte only), chosen per word.
- Handles the UART TX valid/busy handshake and guards against a transmitter that never acknowledges.

---
 rtl/tx_frame_ctrl_if.sv | 32 +++
 rtl/tx_frame_ctrl.sv | 130 +++++++++++++
 tb/tb_tx_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_frame_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_frame_ctrl_if : FIFO read port + UART TX handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface tx_frame_ctrl_if #(
  parameter int BUS_WIDTH  = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  tx_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  byte_mode;
  logic                  tx_busy;
  logic                  fifo_rd_inc;
  logic [BUS_WIDTH-1:0]  tx_p_data;
  logic                  tx_data_valid;
  logic                  ctrl_busy;
  logic                  timeout_err;

  // master = environment (FIFO + UART), slave = the frame controller
  modport master (
    output tx_en, fifo_empty, fifo_rd_data, byte_mode, tx_busy,
    input  fifo_rd_inc, tx_p_data, tx_data_valid, ctrl_busy, timeout_err
  );

  modport slave (
    input  tx_en, fifo_empty, fifo_rd_data, byte_mode, tx_busy,
    output fifo_rd_inc, tx_p_data, tx_data_valid, ctrl_busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/tx_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_frame_ctrl : drains 16-bit FIFO words to the UART TX, low byte first
// Revision: 1.0
// ---------------------------------------------------------------------------
module tx_frame_ctrl #(
  parameter int BUS_WIDTH    = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic           CLK,
  input  logic           RST,
  tx_frame_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    POP        = 3'd1,
    SEND       = 3'd2,
    WAIT_START = 3'd3,
    WAIT_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] c_timeout_last = 8'(BUSY_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  mode_q, mode_d;
  logic                  byte_idx_q, byte_idx_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  fifo_rd_inc_q, fifo_rd_inc_d;
  logic [BUS_WIDTH-1:0]  tx_p_data_q, tx_p_data_d;
  logic                  tx_data_valid_q, tx_data_valid_d;
  logic                  ctrl_busy_q, ctrl_busy_d;
  logic                  timeout_err_q, timeout_err_d;

  always_comb begin
    state_d         = state_q;
    word_d          = word_q;
    mode_d          = mode_q;
    byte_idx_d      = byte_idx_q;
    cnt_d           = cnt_q;
    fifo_rd_inc_d   = 1'b0;
    tx_p_data_d     = tx_p_data_q;
    tx_data_valid_d = 1'b0;
    timeout_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.tx_en && !bus.fifo_empty) begin
          word_d        = bus.fifo_rd_data;
          mode_d        = bus.byte_mode;
          byte_idx_d    = 1'b0;
          fifo_rd_inc_d = 1'b1;
          state_d       = POP;
        end
      end
      POP: begin
        state_d = SEND;
      end
      SEND: begin
        if (!bus.tx_busy) begin
          tx_p_data_d     = byte_idx_q ? word_q[DATA_WIDTH-1 -: BUS_WIDTH]
                                       : word_q[BUS_WIDTH-1:0];
          tx_data_valid_d = 1'b1;
          cnt_d           = '0;
          state_d         = WAIT_START;
        end
      end
      WAIT_START: begin
        // Transmitter never acknowledged: drop the remainder of the word.
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == c_timeout_last) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (!byte_idx_q && !mode_q) begin
            byte_idx_d = 1'b1;
            state_d    = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ctrl_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      word_q          <= '0;
      mode_q          <= 1'b0;
      byte_idx_q      <= 1'b0;
      cnt_q           <= '0;
      fifo_rd_inc_q   <= 1'b0;
      tx_p_data_q     <= '0;
      tx_data_valid_q <= 1'b0;
      ctrl_busy_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_q          <= word_d;
      mode_q          <= mode_d;
      byte_idx_q      <= byte_idx_d;
      cnt_q           <= cnt_d;
      fifo_rd_inc_q   <= fifo_rd_inc_d;
      tx_p_data_q     <= tx_p_data_d;
      tx_data_valid_q <= tx_data_valid_d;
      ctrl_busy_q     <= ctrl_busy_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign bus.fifo_rd_inc   = fifo_rd_inc_q;
  assign bus.tx_p_data     = tx_p_data_q;
  assign bus.tx_data_valid = tx_data_valid_q;
  assign bus.ctrl_busy     = ctrl_busy_q;
  assign bus.timeout_err   = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tx_frame_ctrl : directed bench with a FIFO queue and a simple UART model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tx_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  tx_frame_ctrl_if #(.BUS_WIDTH(8), .DATA_WIDTH(16)) bus ();

  tx_frame_ctrl #(
    .BUS_WIDTH   (8),
    .DATA_WIDTH  (16),
    .BUSY_TIMEOUT(8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FIFO model and event logs
  logic [15:0] fifo[$];
  int          rd_cyc[$];
  int          val_cyc[$];
  logic [7:0]  val_byte[$];
  int          to_cyc[$];
  int          b2b = 0;
  logic        rd_prev = 1'b0;

  task automatic fifo_drive();
    bus.fifo_empty   = (fifo.size() == 0);
    bus.fifo_rd_data = (fifo.size() != 0) ? fifo[0] : 16'h0;
  endtask

  task automatic push(input logic [15:0] w);
    fifo.push_back(w);
    fifo_drive();
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    val_cyc.delete();
    val_byte.delete();
    to_cyc.delete();
  endtask

  initial forever begin
    @(negedge clk);
    if (bus.fifo_rd_inc) begin
      rd_cyc.push_back(cyc);
      if (rd_prev) b2b++;
      if (fifo.size() != 0) void'(fifo.pop_front());
      fifo_drive();
    end
    rd_prev = bus.fifo_rd_inc;
    if (bus.tx_data_valid) begin
      val_cyc.push_back(cyc);
      val_byte.push_back(bus.tx_p_data);
    end
    if (bus.timeout_err) to_cyc.push_back(cyc);
  end

  // UART model: busy rises the cycle after a valid, held uart_hold cycles
  logic uart_auto = 1'b0;
  int   uart_hold = 10;

  initial forever begin
    @(negedge clk);
    if (bus.tx_data_valid && uart_auto) begin
      @(posedge clk); #1;
      bus.tx_busy = 1'b1;
      repeat (uart_hold) @(posedge clk);
      #1;
      bus.tx_busy = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int idle_cyc;

  task automatic wait_idle(input string tag, input int max);
    int  k = 0;
    logic idle;
    do begin
      @(negedge clk);
      k++;
      idle = !bus.ctrl_busy && (fifo.size() == 0 || !bus.tx_en);
    end while (!idle && k < max);
    check_eq(tag, 32'(idle), 32'd1);
    idle_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic wait_vals(input string tag, input int n, input int max);
    int k = 0;
    while (val_cyc.size() < n && k < max) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(val_cyc.size() >= n), 32'd1);
    @(posedge clk); #1;
  endtask

  int c0;

  initial begin
    bus.tx_en     = 1'b0;
    bus.byte_mode = 1'b0;
    bus.tx_busy   = 1'b0;
    fifo_drive();

    // Reset state
    tick(3);
    @(negedge clk);
    check_eq("rst_rd_inc", 32'(bus.fifo_rd_inc), 32'd0);
    check_eq("rst_data",   32'(bus.tx_p_data), 32'd0);
    check_eq("rst_valid",  32'(bus.tx_data_valid), 32'd0);
    check_eq("rst_busy",   32'(bus.ctrl_busy), 32'd0);
    check_eq("rst_tmo",    32'(bus.timeout_err), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Two-byte word
    bus.tx_en = 1'b1; uart_auto = 1'b1; uart_hold = 10;
    clear_logs();
    push(16'hA55A); c0 = cyc;
    wait_idle("t1_idle", 200);
    check_eq("t1_rd_cnt",  32'(rd_cyc.size()), 32'd1);
    check_eq("t1_val_cnt", 32'(val_cyc.size()), 32'd2);
    if (rd_cyc.size() == 1) check_eq("t1_rd_lat", 32'(rd_cyc[0] - c0), 32'd1);
    if (val_cyc.size() == 2) begin
      check_eq("t1_val0_lat", 32'(val_cyc[0] - c0), 32'd3);
      check_eq("t1_val1_lat", 32'(val_cyc[1] - c0), 32'd16);
      check_eq("t1_byte0", 32'(val_byte[0]), 32'h5A);
      check_eq("t1_byte1", 32'(val_byte[1]), 32'hA5);
    end
    check_eq("t1_idle_cyc", 32'(idle_cyc - c0), 32'd28);

    // Single-byte mode; BYTE_MODE change after pop must not matter
    tick(2);
    bus.byte_mode = 1'b1;
    clear_logs();
    push(16'h00C3); c0 = cyc;
    tick(2);
    bus.byte_mode = 1'b0;
    wait_idle("t2_idle", 200);
    check_eq("t2_val_cnt", 32'(val_cyc.size()), 32'd1);
    if (val_cyc.size() == 1) check_eq("t2_byte", 32'(val_byte[0]), 32'hC3);
    check_eq("t2_idle_cyc", 32'(idle_cyc - c0), 32'd15);
    check_eq("t2_txbusy_low", 32'(bus.tx_busy), 32'd0);

    // Backpressure: TX_BUSY already high when SEND is entered
    tick(2);
    bus.byte_mode = 1'b1;
    uart_auto = 1'b0;
    bus.tx_busy = 1'b1;
    clear_logs();
    push(16'h0077); c0 = cyc;
    tick(20);
    check_eq("t3_no_early_val", 32'(val_cyc.size()), 32'd0);
    uart_auto = 1'b1;
    bus.tx_busy = 1'b0;
    wait_idle("t3_idle", 200);
    check_eq("t3_rd_cnt", 32'(rd_cyc.size()), 32'd1);
    check_eq("t3_val_cnt", 32'(val_cyc.size()), 32'd1);
    if (val_cyc.size() == 1) begin
      check_eq("t3_val_lat", 32'(val_cyc[0] - c0), 32'd21);
      check_eq("t3_byte", 32'(val_byte[0]), 32'h77);
    end
    check_eq("t3_idle_cyc", 32'(idle_cyc - c0), 32'd33);

    // Timeout on first byte, next word proceeds normally
    tick(2);
    bus.byte_mode = 1'b0;
    uart_auto = 1'b0;
    clear_logs();
    push(16'hBEEF); push(16'h1234); c0 = cyc;
    tick(5);
    uart_auto = 1'b1;
    wait_vals("t4_vals", 3, 200);
    wait_idle("t4_idle", 200);
    check_eq("t4_tmo_cnt", 32'(to_cyc.size()), 32'd1);
    check_eq("t4_val_cnt", 32'(val_cyc.size()), 32'd3);
    check_eq("t4_rd_cnt", 32'(rd_cyc.size()), 32'd2);
    if (to_cyc.size() == 1 && val_cyc.size() == 3) begin
      check_eq("t4_tmo_lat", 32'(to_cyc[0] - val_cyc[0]), 32'd8);
      check_eq("t4_byte0", 32'(val_byte[0]), 32'hEF);
      check_eq("t4_byte1", 32'(val_byte[1]), 32'h34);
      check_eq("t4_byte2", 32'(val_byte[2]), 32'h12);
    end
    if (rd_cyc.size() == 2) check_eq("t4_rd1_lat", 32'(rd_cyc[1] - c0), 32'd12);

    // Back-to-back words with TX_EN dropped during the first
    tick(2);
    clear_logs();
    push(16'h1111); push(16'h2222); c0 = cyc;
    tick(2);
    bus.tx_en = 1'b0;
    wait_idle("t5_idle_a", 200);
    check_eq("t5_first_done", 32'(idle_cyc - c0), 32'd28);
    tick(c0 + 40 - cyc);
    check_eq("t5_rd_cnt_hold", 32'(rd_cyc.size()), 32'd1);
    check_eq("t5_busy_hold", 32'(bus.ctrl_busy), 32'd0);
    bus.tx_en = 1'b1;
    wait_vals("t5_vals", 4, 200);
    wait_idle("t5_idle_b", 200);
    check_eq("t5_rd_cnt", 32'(rd_cyc.size()), 32'd2);
    if (rd_cyc.size() == 2) check_eq("t5_rd1_lat", 32'(rd_cyc[1] - c0), 32'd41);
    if (val_byte.size() == 4)
      check_eq("t5_bytes", {val_byte[0], val_byte[1], val_byte[2], val_byte[3]}, 32'h11112222);
    else
      check_eq("t5_val_cnt", 32'(val_byte.size()), 32'd4);

    // Reset in WAIT_DONE after the low byte
    tick(2);
    clear_logs();
    push(16'hCAFE); push(16'h5678); c0 = cyc;
    tick(8);
    rst = 1'b1;
    tick(1);
    check_eq("t6_rst_rd_inc", 32'(bus.fifo_rd_inc), 32'd0);
    check_eq("t6_rst_data",   32'(bus.tx_p_data), 32'd0);
    check_eq("t6_rst_valid",  32'(bus.tx_data_valid), 32'd0);
    check_eq("t6_rst_busy",   32'(bus.ctrl_busy), 32'd0);
    check_eq("t6_rst_tmo",    32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
    wait_vals("t6_vals", 3, 200);
    wait_idle("t6_idle", 200);
    check_eq("t6_rd_cnt", 32'(rd_cyc.size()), 32'd2);
    if (val_byte.size() == 3)
      check_eq("t6_bytes", {8'h0, val_byte[0], val_byte[1], val_byte[2]}, 32'h00FE7856);
    else
      check_eq("t6_val_cnt", 32'(val_byte.size()), 32'd3);

    check_eq("no_b2b_rd_inc", 32'(b2b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
